// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared types and constants for the frame sequencer.
//   state_t  - scheduler states (scan for blanking, sample buttons, wait for update)
//   BTN_*    - bit positions of each button in the 5-bit button vectors
//   NUM_BTN  - number of push buttons
package frame_seq_pkg;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    SAMPLE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int BTN_C   = 0;
  localparam int BTN_U   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_R   = 3;
  localparam int BTN_L   = 4;
  localparam int NUM_BTN = 5;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one push-button channel.
//   Two-flop synchronizer on the raw button, then a per-frame debounce counter.
//   The counter only advances on sample_en (one cycle per frame).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   raw        - asynchronous button input
//   sample_en  - high for the single per-frame sample cycle
//   level      - debounced button level
//   press      - rising edge of level from the last sample, held until the next
//   rise       - combinational: this sample cycle will produce a rising edge
module btn_debounce
  import frame_seq_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic sample_en,
  output logic level,
  output logic press,
  output logic rise
);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] cnt;
  logic       differs;
  logic       hit;

  assign differs = (sync_p1 != level);
  // The sample that would bring the counter to DEBOUNCE_FRAMES toggles the
  // level directly, so the counter never actually holds that value.
  assign hit     = differs && (cnt == 4'(DEBOUNCE_FRAMES - 1));
  assign rise    = sample_en && hit && !level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= 4'd0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      // synchronizer stages
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // per-frame debounce sample
      if (sample_en) begin
        press <= hit && !level;
        if (hit) begin
          level <= ~level;
          cnt   <= 4'd0;
        end else if (differs) begin
          cnt <= cnt + 4'd1;
        end else begin
          cnt <= 4'd0;
        end
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame game scheduler.
//   Detects blanking start, samples/debounces five buttons once per frame, and
//   runs one update request/acknowledge with the game logic, which must finish
//   before the next frame begins at coordinate (0,0). Owns pause mode and the
//   completed-update counter.
// Ports:
//   pixel_clk, sim_rst    - clock, synchronous active-high reset
//   h_coord, v_coord      - display controller coordinates
//   button_c/u/d/r/l      - raw asynchronous buttons
//   frame_start           - one-cycle pulse (SAMPLE state) at blanking start
//   upd_req / upd_done    - update handshake with the game logic
//   btn_state, btn_press  - debounced levels / rising edges, {l,r,d,u,c}
//   paused                - pause mode, toggled by a centre-button press
//   frame_cnt             - completed updates, wrapping
//   deadline_err          - sticky: an update was aborted at frame start
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic        pixel_clk,
  input  logic        sim_rst,
  input  logic [9:0]  h_coord,
  input  logic [9:0]  v_coord,
  input  logic        button_c,
  input  logic        button_u,
  input  logic        button_d,
  input  logic        button_r,
  input  logic        button_l,
  output logic        frame_start,
  output logic        upd_req,
  input  logic        upd_done,
  output logic [4:0]  btn_state,
  output logic [4:0]  btn_press,
  output logic        paused,
  output logic [15:0] frame_cnt,
  output logic        deadline_err
);

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 || H_ACTIVE < 1 ||
      V_ACTIVE < 1 || V_ACTIVE > 1023) begin : g_bad_params
    $error("frame_sequencer: parameter out of range");
  end

  state_t               state;
  state_t               state_next;
  logic [NUM_BTN-1:0]   raw_btn;
  logic [NUM_BTN-1:0]   rise;
  logic                 sample_en;
  logic                 blank_hit;
  logic                 frame_hit;
  logic                 pause_next;
  logic                 unused_rise;

  assign raw_btn   = {button_l, button_r, button_d, button_u, button_c};
  assign sample_en = (state == SAMPLE);
  assign blank_hit = (v_coord == 10'(V_ACTIVE)) && (h_coord == 10'd0);
  assign frame_hit = (v_coord == 10'd0) && (h_coord == 10'd0);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_deb (
      .clk      (pixel_clk),
      .rst      (sim_rst),
      .raw      (raw_btn[i]),
      .sample_en(sample_en),
      .level    (btn_state[i]),
      .press    (btn_press[i]),
      .rise     (rise[i])
    );
  end

  // Only the centre button affects control flow.
  assign unused_rise = ^rise[NUM_BTN-1:1];

  // The run/pause decision in SAMPLE needs the pause mode after this frame's
  // toggle, so it comes from the combinational rise rather than btn_press.
  assign pause_next = paused ^ rise[BTN_C];

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    upd_req     = 1'b0;
    unique case (state)
      SCAN: begin
        if (blank_hit) state_next = SAMPLE;
      end
      SAMPLE: begin
        frame_start = 1'b1;
        state_next  = pause_next ? SCAN : WAIT;
      end
      WAIT: begin
        upd_req = 1'b1;
        if (upd_done || frame_hit) state_next = SCAN;
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (sim_rst) begin
      state        <= SCAN;
      paused       <= 1'b0;
      frame_cnt    <= 16'd0;
      deadline_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == SAMPLE) paused <= pause_next;
      // acknowledge wins over a coincident abort
      if (state == WAIT) begin
        if (upd_done)       frame_cnt    <= frame_cnt + 16'd1;
        else if (frame_hit) deadline_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed self-checking bench for frame_sequencer.
// Coordinates are driven directly: one blanking-start cycle per frame, then
// idle coordinates, with an optional (0,0) cycle to model the next frame.
module tb_frame_sequencer;

  logic        pixel_clk = 1'b0;
  logic        sim_rst   = 1'b1;
  logic [9:0]  h_coord   = 10'd1;
  logic [9:0]  v_coord   = 10'd481;
  logic        button_c  = 1'b0;
  logic        button_u  = 1'b0;
  logic        button_d  = 1'b0;
  logic        button_r  = 1'b0;
  logic        button_l  = 1'b0;
  logic        upd_done  = 1'b0;
  logic        frame_start;
  logic        upd_req;
  logic [4:0]  btn_state;
  logic [4:0]  btn_press;
  logic        paused;
  logic [15:0] frame_cnt;
  logic        deadline_err;

  int tests = 0;
  int fails = 0;

  frame_sequencer #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .pixel_clk   (pixel_clk),
    .sim_rst     (sim_rst),
    .h_coord     (h_coord),
    .v_coord     (v_coord),
    .button_c    (button_c),
    .button_u    (button_u),
    .button_d    (button_d),
    .button_r    (button_r),
    .button_l    (button_l),
    .frame_start (frame_start),
    .upd_req     (upd_req),
    .upd_done    (upd_done),
    .btn_state   (btn_state),
    .btn_press   (btn_press),
    .paused      (paused),
    .frame_cnt   (frame_cnt),
    .deadline_err(deadline_err)
  );

  initial forever #5 pixel_clk = ~pixel_clk;

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset();
    sim_rst = 1'b1;
    step();
    step();
    sim_rst = 1'b0;
  endtask

  // One frame: blanking-start coordinate for one cycle, then 12 idle cycles.
  // done_dly / abort_dly: index of the request cycle (0 = first cycle upd_req
  // is seen high) at which upd_done is raised / (0,0) is driven; -1 = never.
  task automatic run_frame(input int done_dly, input int abort_dly,
                           output int req_n, output int fs_n);
    req_n = 0;
    fs_n  = 0;
    v_coord = 10'd480;
    h_coord = 10'd0;
    step();
    for (int i = 0; i < 12; i++) begin
      fs_n += int'(frame_start);
      upd_done = 1'b0;
      v_coord  = 10'd481;
      h_coord  = 10'd1;
      if (upd_req) begin
        if (done_dly == req_n) upd_done = 1'b1;
        if (abort_dly == req_n) begin
          v_coord = 10'd0;
          h_coord = 10'd0;
        end
        req_n++;
      end
      step();
    end
    upd_done = 1'b0;
    v_coord  = 10'd481;
    h_coord  = 10'd1;
  endtask

  task automatic test_reset();
    sim_rst = 1'b1;
    step();
    step();
    tests++;
    if ({frame_start, upd_req, btn_state, btn_press, paused, frame_cnt, deadline_err} !== 30'd0) begin
      fails++;
      $display("FAIL reset_outputs got fs=%0b req=%0b st=%b pr=%b p=%0b cnt=%0d err=%0b want all 0",
               frame_start, upd_req, btn_state, btn_press, paused, frame_cnt, deadline_err);
    end
    sim_rst = 1'b0;
    // acknowledge outside WAIT must not count
    upd_done = 1'b1;
    step();
    step();
    step();
    upd_done = 1'b0;
    tests++;
    if (frame_cnt !== 16'd0 || upd_req !== 1'b0) begin
      fails++;
      $display("FAIL done_outside_wait got cnt=%0d req=%0b want 0 0", frame_cnt, upd_req);
    end
  endtask

  task automatic test_two_frames();
    int req_n, fs_n;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      run_frame(5, -1, req_n, fs_n);
      tests++;
      if (fs_n !== 1) begin
        fails++;
        $display("FAIL frame%0d_start_pulses got %0d want 1", f, fs_n);
      end
      tests++;
      if (req_n !== 6) begin
        fails++;
        $display("FAIL frame%0d_req_cycles got %0d want 6", f, req_n);
      end
    end
    tests++;
    if (frame_cnt !== 16'd2 || deadline_err !== 1'b0) begin
      fails++;
      $display("FAIL two_frames_cnt got cnt=%0d err=%0b want 2 0", frame_cnt, deadline_err);
    end
    // earliest acknowledge: done on the first request cycle
    run_frame(0, -1, req_n, fs_n);
    tests++;
    if (req_n !== 1 || frame_cnt !== 16'd3) begin
      fails++;
      $display("FAIL earliest_ack got req=%0d cnt=%0d want 1 3", req_n, frame_cnt);
    end
  endtask

  task automatic test_button_hold();
    int req_n, fs_n;
    logic [4:0] exp_state [4];
    logic [4:0] exp_press [4];
    exp_state = '{5'b00000, 5'b00000, 5'b00010, 5'b00010};
    exp_press = '{5'b00000, 5'b00000, 5'b00010, 5'b00000};
    do_reset();
    button_u = 1'b1;
    step();
    step();
    step();
    for (int f = 0; f < 4; f++) begin
      run_frame(0, -1, req_n, fs_n);
      tests++;
      if (btn_state !== exp_state[f] || btn_press !== exp_press[f]) begin
        fails++;
        $display("FAIL hold_u_frame%0d got st=%b pr=%b want st=%b pr=%b",
                 f + 1, btn_state, btn_press, exp_state[f], exp_press[f]);
      end
    end
    button_u = 1'b0;
  endtask

  task automatic test_button_glitch();
    int req_n, fs_n;
    do_reset();
    button_u = 1'b1;
    step();
    step();
    step();
    run_frame(0, -1, req_n, fs_n);
    run_frame(0, -1, req_n, fs_n);
    button_u = 1'b0;
    step();
    step();
    step();
    for (int f = 0; f < 2; f++) begin
      run_frame(0, -1, req_n, fs_n);
      tests++;
      if (btn_state !== 5'b0 || btn_press !== 5'b0) begin
        fails++;
        $display("FAIL glitch_frame%0d got st=%b pr=%b want 0 0", f + 3, btn_state, btn_press);
      end
    end
  endtask

  task automatic test_pause();
    int req_n, fs_n;
    do_reset();
    button_c = 1'b1;
    step();
    step();
    step();
    run_frame(0, -1, req_n, fs_n);
    run_frame(0, -1, req_n, fs_n);
    run_frame(0, -1, req_n, fs_n);
    tests++;
    if (req_n !== 0 || paused !== 1'b1 || btn_press !== 5'b00001 || frame_cnt !== 16'd2) begin
      fails++;
      $display("FAIL pause_enter got req=%0d p=%0b pr=%b cnt=%0d want 0 1 00001 2",
               req_n, paused, btn_press, frame_cnt);
    end
    button_c = 1'b0;
    step();
    step();
    step();
    for (int f = 4; f <= 8; f++) begin
      if (f == 7) begin
        button_c = 1'b1;
        step();
        step();
        step();
      end
      run_frame(0, -1, req_n, fs_n);
      tests++;
      if (req_n !== 0 || paused !== 1'b1 || frame_cnt !== 16'd2) begin
        fails++;
        $display("FAIL paused_frame%0d got req=%0d p=%0b cnt=%0d want 0 1 2",
                 f, req_n, paused, frame_cnt);
      end
    end
    run_frame(0, -1, req_n, fs_n);
    tests++;
    if (req_n !== 1 || paused !== 1'b0 || frame_cnt !== 16'd3) begin
      fails++;
      $display("FAIL pause_resume got req=%0d p=%0b cnt=%0d want 1 0 3", req_n, paused, frame_cnt);
    end
    button_c = 1'b0;
  endtask

  task automatic test_deadline();
    int req_n, fs_n;
    do_reset();
    run_frame(2, 2, req_n, fs_n);
    tests++;
    if (req_n !== 3 || frame_cnt !== 16'd1 || deadline_err !== 1'b0) begin
      fails++;
      $display("FAIL coincident_done got req=%0d cnt=%0d err=%0b want 3 1 0",
               req_n, frame_cnt, deadline_err);
    end
    run_frame(-1, 3, req_n, fs_n);
    tests++;
    if (req_n !== 4 || frame_cnt !== 16'd1 || deadline_err !== 1'b1) begin
      fails++;
      $display("FAIL deadline_abort got req=%0d cnt=%0d err=%0b want 4 1 1",
               req_n, frame_cnt, deadline_err);
    end
    run_frame(1, -1, req_n, fs_n);
    tests++;
    if (req_n !== 2 || frame_cnt !== 16'd2 || deadline_err !== 1'b1) begin
      fails++;
      $display("FAIL deadline_sticky got req=%0d cnt=%0d err=%0b want 2 2 1",
               req_n, frame_cnt, deadline_err);
    end
  endtask

  task automatic test_wrap();
    int req_n, fs_n;
    logic [15:0] exp_cnt [3];
    exp_cnt = '{16'hFFFE, 16'hFFFF, 16'h0000};
    do_reset();
    force dut.frame_cnt = 16'hFFFD;
    step();
    release dut.frame_cnt;
    step();
    for (int f = 0; f < 3; f++) begin
      run_frame(0, -1, req_n, fs_n);
      tests++;
      if (frame_cnt !== exp_cnt[f]) begin
        fails++;
        $display("FAIL wrap_step%0d got %h want %h", f, frame_cnt, exp_cnt[f]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int req_n, fs_n;
    do_reset();
    button_u = 1'b1;
    step();
    step();
    step();
    run_frame(0, -1, req_n, fs_n);
    run_frame(0, -1, req_n, fs_n);
    run_frame(0, -1, req_n, fs_n);
    run_frame(-1, 2, req_n, fs_n);
    v_coord = 10'd480;
    h_coord = 10'd0;
    step();
    v_coord = 10'd481;
    h_coord = 10'd1;
    step();
    tests++;
    if (upd_req !== 1'b1 || btn_state !== 5'b00010 || frame_cnt !== 16'd3 || deadline_err !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_wait got req=%0b st=%b cnt=%0d err=%0b want 1 00010 3 1",
               upd_req, btn_state, frame_cnt, deadline_err);
    end
    sim_rst = 1'b1;
    step();
    tests++;
    if ({frame_start, upd_req, btn_state, btn_press, paused, frame_cnt, deadline_err} !== 30'd0) begin
      fails++;
      $display("FAIL reset_mid_wait got fs=%0b req=%0b st=%b pr=%b p=%0b cnt=%0d err=%0b want all 0",
               frame_start, upd_req, btn_state, btn_press, paused, frame_cnt, deadline_err);
    end
    sim_rst  = 1'b0;
    button_u = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_button_hold();
    test_button_glitch();
    test_pause();
    test_deadline();
    test_wrap();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
